poly_feeder: RTL and testbench
==============================

POLY_FEEDER -- requirements
Module: poly_feeder

Interface
REQ-001 SHALL have parameter GO_LOW_CYCLES, default 2: cycles data_out is held with go low before each strobe (legal 1..15).
REQ-002 SHALL have parameter GO_HIGH_CYCLES, default 2: cycles go is held high per operand (legal 1..15).
REQ-003 SHALL have parameter COMPUTE_CYCLES, default 8: cycles waited after the last strobe before sampling result_in (legal 1..255).
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports in_a, in_b, in_c, in_x  input  8 each  operand bundle, sampled only on acceptance.
REQ-007 SHALL have port in_valid  input  1  operand bundle present.
REQ-008 SHALL have port in_ready  output  1  block can accept a bundle.
REQ-009 SHALL have port go  output  1  load strobe to the downstream evaluator.
REQ-010 SHALL have port data_out  output  8  operand presented to the downstream evaluator.
REQ-011 SHALL have port result_in  input  8  evaluator result register.
REQ-012 SHALL have port result_out  output  8  captured result.
REQ-013 SHALL have port done  output  1  one-cycle pulse: result_out newly valid.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, SETUP, STROBE, COMPUTE, DONE, a 2-bit operand index (0=A, 1=B, 2=C, 3=X) and an 8-bit cycle counter.
REQ-016 in_ready SHALL be 1 exactly in IDLE (combinational from state); acceptance = in_valid && in_ready at a clock edge.
REQ-017 On acceptance SHALL latch in_a..in_x into internal registers, set index=0 and enter SETUP; later in_* changes SHALL have no effect until the next acceptance.
REQ-018 SETUP SHALL last exactly GO_LOW_CYCLES cycles with go=0 and data_out=operand[index], then enter STROBE.
REQ-019 STROBE SHALL last exactly GO_HIGH_CYCLES cycles with go=1 and data_out=operand[index].
REQ-020 On leaving STROBE: index<3 -> index+1 and enter SETUP; index==3 -> enter COMPUTE.
REQ-021 data_out SHALL be unchanged from the first SETUP cycle through the last STROBE cycle of each operand; go SHALL never be high in IDLE, COMPUTE or DONE.
REQ-022 COMPUTE SHALL last exactly COMPUTE_CYCLES cycles with go=0 and data_out=latched X; at the clock edge ending the last COMPUTE cycle result_out SHALL load result_in.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE; done SHALL be 0 in all other states.
REQ-024 Latency with defaults: acceptance in cycle 0 -> go high in cycles 3-4, 7-8, 11-12, 15-16 -> COMPUTE cycles 17-24 -> done=1 in cycle 25 -> in_ready=1 in cycle 26.
REQ-025 in_valid while not IDLE SHALL be ignored (in_ready=0) and SHALL not disturb the sequence; back-to-back bundles SHALL be separated by at least the DONE cycle.
REQ-026 result_out SHALL hold its value between captures, including across IDLE.
REQ-027 Parameter values out of legal range SHALL be flagged by a simulation-time error; counter widths SHALL not wrap for legal values.

Reset
REQ-028 resetn=0 sampled at a clock edge SHALL force IDLE, index=0, counter=0, go=0, data_out=0, result_out=0, done=0, latched operands=0; in_ready=1 and busy=0 from the following cycle.
REQ-029 Reset mid-sequence (any state) SHALL abort without completing the current strobe; go SHALL be 0 in the cycle following the reset edge.
REQ-030 resetn=0 SHALL take priority over a simultaneous acceptance.

Verification
REQ-031 Defaults, bundle A=1,B=2,C=3,X=4, result_in driven 0x1B from cycle 20 -> go pulses cycles 3-4/7-8/11-12/15-16 with data_out 1,2,3,4; done cycle 25; result_out=0x1B.
REQ-032 Integration with the downstream evaluator: A=2,B=3,C=1,X=5 -> done pulse with result_out equal to evaluator's data_result after its final cycle, and evaluator back in its first load state.
REQ-033 in_valid held high continuously with changing operands -> second bundle accepted only in cycle 26; first run uses only the operands present in cycle 0.
REQ-034 resetn=0 during second STROBE (cycle 8) -> go=0, data_out=0, in_ready=1 next cycle; new bundle then completes normally.
REQ-035 GO_LOW_CYCLES=1, GO_HIGH_CYCLES=1, COMPUTE_CYCLES=1 -> go high cycles 2,4,6,8; done cycle 10.

Source files
------------

// File: rtl/poly_feeder.sv
// poly_feeder: latches an A/B/C/X operand bundle, strobes each operand to a downstream
// evaluator with programmable setup/strobe timing, then waits and captures the evaluator result.
module poly_feeder #(
    parameter int GO_LOW_CYCLES  = 2,
    parameter int GO_HIGH_CYCLES = 2,
    parameter int COMPUTE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic [7:0] in_c,
    input  logic [7:0] in_x,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       go,
    output logic [7:0] data_out,
    input  logic [7:0] result_in,
    output logic [7:0] result_out,
    output logic       done,
    output logic       busy
);
    if (GO_LOW_CYCLES < 1 || GO_LOW_CYCLES > 15 || GO_HIGH_CYCLES < 1 || GO_HIGH_CYCLES > 15 ||
        COMPUTE_CYCLES < 1 || COMPUTE_CYCLES > 255) begin : g_param_err
        $error("poly_feeder: timing parameter out of legal range");
    end
    localparam logic [7:0] LOW_LAST  = 8'(GO_LOW_CYCLES - 1);
    localparam logic [7:0] HIGH_LAST = 8'(GO_HIGH_CYCLES - 1);
    localparam logic [7:0] COMP_LAST = 8'(COMPUTE_CYCLES - 1);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, COMPUTE, DONE} state_t;
    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [3:0][7:0] op_q, op_d;
    logic            go_q, go_d;
    logic [7:0]      dout_q, dout_d;
    logic [7:0]      res_q, res_d;
    logic            done_q, done_d;
    assign in_ready   = state_q == IDLE;
    assign busy       = state_q != IDLE;
    assign go         = go_q;
    assign data_out   = dout_q;
    assign result_out = res_q;
    assign done       = done_q;
    // go, data_out and done are computed for the next state so they stay glitch-free flops
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 8'd1;
        op_d    = op_q;
        go_d    = 1'b0;
        dout_d  = dout_q;
        res_d   = res_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (in_valid) begin
                    op_d    = {in_x, in_c, in_b, in_a};
                    idx_d   = '0;
                    dout_d  = in_a;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == LOW_LAST) begin
                    cnt_d   = '0;
                    state_d = STROBE;
                end
                go_d = cnt_q == LOW_LAST;
            end
            STROBE: begin
                go_d = cnt_q != HIGH_LAST;
                if (cnt_q == HIGH_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 2'd3) begin
                        state_d = COMPUTE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        dout_d  = op_q[idx_q + 2'd1];
                        state_d = SETUP;
                    end
                end
            end
            COMPUTE: begin
                if (cnt_q == COMP_LAST) begin
                    cnt_d   = '0;
                    res_d   = result_in;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            go_q    <= 1'b0;
            dout_q  <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            go_q    <= go_d;
            dout_q  <= dout_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_poly_feeder.sv
// tb_poly_feeder: cycle-table check of the default feeder with a behavioural evaluator,
// plus a hand-written sequence for the fastest legal timing.
module tb_poly_feeder;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] in_a = '0, in_b = '0, in_c = '0, in_x = '0;
    logic       in_valid = 1'b0, in_valid2 = 1'b0;
    logic       in_ready, go, done, busy;
    logic [7:0] data_out, result_in, result_out;
    logic       in_ready2, go2, done2, busy2;
    logic [7:0] data_out2, result_out2;
    logic [7:0] result_in2 = 8'h5C;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [1:0] ev_slot;
    logic [7:0] ev_a, ev_b, ev_c, ev_res;
    logic       ev_go_q;

    always #5 clk = ~clk;

    poly_feeder dut (
        .clk(clk), .resetn(resetn), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_x(in_x),
        .in_valid(in_valid), .in_ready(in_ready), .go(go), .data_out(data_out),
        .result_in(result_in), .result_out(result_out), .done(done), .busy(busy)
    );
    poly_feeder #(.GO_LOW_CYCLES(1), .GO_HIGH_CYCLES(1), .COMPUTE_CYCLES(1)) dut_fast (
        .clk(clk), .resetn(resetn), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_x(in_x),
        .in_valid(in_valid2), .in_ready(in_ready2), .go(go2), .data_out(data_out2),
        .result_in(result_in2), .result_out(result_out2), .done(done2), .busy(busy2)
    );

    // evaluator: loads A,B,C,X on successive go rising edges, then computes a*x^2+b*x+c
    always @(posedge clk) begin
        if (!resetn) begin
            ev_slot <= '0;
            ev_a    <= '0;
            ev_b    <= '0;
            ev_c    <= '0;
            ev_res  <= '0;
            ev_go_q <= 1'b0;
        end else begin
            ev_go_q <= go;
            if (go && !ev_go_q) begin
                ev_slot <= ev_slot + 2'd1;
                if (ev_slot == 2'd0) ev_a <= data_out;
                if (ev_slot == 2'd1) ev_b <= data_out;
                if (ev_slot == 2'd2) ev_c <= data_out;
                if (ev_slot == 2'd3) ev_res <= 8'(ev_a * data_out * data_out + ev_b * data_out + ev_c);
            end
        end
    end

    assign result_in = cyc < 20 ? 8'hEE : cyc < 35 ? 8'h1B : ev_res;

    typedef struct {
        int         cyc;
        logic       go;
        logic       dv;
        logic [7:0] dout;
        logic       done;
        logic       rdy;
        logic       busy;
        logic [7:0] res;
    } vec_t;
    vec_t tbl [30];
    logic [11:0] go_pat2;
    logic [7:0]  dat2 [4];

    task automatic chk(input string nm, input int c, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h want %h", nm, c, act, exp);
        end
    endtask

    initial begin
        tbl = '{
            '{0,  0, 1, 8'h00, 0, 1, 0, 8'h00},
            '{1,  0, 1, 8'h01, 0, 0, 1, 8'h00},
            '{2,  0, 1, 8'h01, 0, 0, 1, 8'h00},
            '{3,  1, 1, 8'h01, 0, 0, 1, 8'h00},
            '{4,  1, 1, 8'h01, 0, 0, 1, 8'h00},
            '{5,  0, 1, 8'h02, 0, 0, 1, 8'h00},
            '{7,  1, 1, 8'h02, 0, 0, 1, 8'h00},
            '{8,  1, 1, 8'h02, 0, 0, 1, 8'h00},
            '{9,  0, 1, 8'h03, 0, 0, 1, 8'h00},
            '{11, 1, 1, 8'h03, 0, 0, 1, 8'h00},
            '{12, 1, 1, 8'h03, 0, 0, 1, 8'h00},
            '{13, 0, 1, 8'h04, 0, 0, 1, 8'h00},
            '{15, 1, 1, 8'h04, 0, 0, 1, 8'h00},
            '{16, 1, 1, 8'h04, 0, 0, 1, 8'h00},
            '{17, 0, 1, 8'h04, 0, 0, 1, 8'h00},
            '{24, 0, 1, 8'h04, 0, 0, 1, 8'h00},
            '{25, 0, 0, 8'h00, 1, 0, 1, 8'h1B},
            '{26, 0, 0, 8'h00, 0, 1, 0, 8'h1B},
            '{27, 0, 1, 8'h2A, 0, 0, 1, 8'h1B},
            '{34, 1, 1, 8'h3A, 0, 0, 1, 8'h1B},
            '{35, 0, 1, 8'h00, 0, 1, 0, 8'h00},
            '{38, 1, 1, 8'h02, 0, 0, 1, 8'h00},
            '{42, 1, 1, 8'h03, 0, 0, 1, 8'h00},
            '{46, 1, 1, 8'h01, 0, 0, 1, 8'h00},
            '{50, 1, 1, 8'h05, 0, 0, 1, 8'h00},
            '{51, 1, 1, 8'h05, 0, 0, 1, 8'h00},
            '{52, 0, 1, 8'h05, 0, 0, 1, 8'h00},
            '{59, 0, 1, 8'h05, 0, 0, 1, 8'h00},
            '{60, 0, 0, 8'h00, 1, 0, 1, 8'h42},
            '{61, 0, 0, 8'h00, 0, 1, 0, 8'h42}
        };
        go_pat2 = 12'h154;
        dat2 = '{8'd9, 8'd8, 8'd7, 8'd6};
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int c = 0; c < 62; c++) begin
            cyc    = c;
            resetn = c != 34;
            if (c == 0) begin
                in_valid = 1'b1;
                {in_a, in_b, in_c, in_x} = {8'd1, 8'd2, 8'd3, 8'd4};
            end else if (c <= 34) begin
                in_valid = 1'b1;
                in_a = 8'(8'h10 + c);
                in_b = 8'(8'h20 + c);
                in_c = 8'(8'h30 + c);
                in_x = 8'(8'h40 + c);
            end else if (c == 35) begin
                in_valid = 1'b1;
                {in_a, in_b, in_c, in_x} = {8'd2, 8'd3, 8'd1, 8'd5};
            end else begin
                in_valid = 1'b0;
                {in_a, in_b, in_c, in_x} = {4{8'hFF}};
            end
            #1;
            for (int i = 0; i < 30; i++) begin
                if (tbl[i].cyc == c) begin
                    chk("go", c, {7'b0, go}, {7'b0, tbl[i].go});
                    if (tbl[i].dv) chk("data_out", c, data_out, tbl[i].dout);
                    chk("done", c, {7'b0, done}, {7'b0, tbl[i].done});
                    chk("in_ready", c, {7'b0, in_ready}, {7'b0, tbl[i].rdy});
                    chk("busy", c, {7'b0, busy}, {7'b0, tbl[i].busy});
                    chk("result_out", c, result_out, tbl[i].res);
                end
            end
            @(posedge clk);
            #1;
        end
        chk("eval_slot", cyc, {6'b0, ev_slot}, 8'h00);
        chk("eval_res", cyc, ev_res, 8'h42);
        for (int r = 0; r < 12; r++) begin
            cyc       = 62 + r;
            in_valid2 = r == 0;
            if (r == 0) {in_a, in_b, in_c, in_x} = {8'd9, 8'd8, 8'd7, 8'd6};
            else {in_a, in_b, in_c, in_x} = {4{8'hA5}};
            #1;
            chk("fast_go", r, {7'b0, go2}, {7'b0, go_pat2[r]});
            chk("fast_done", r, {7'b0, done2}, {7'b0, r == 10});
            chk("fast_ready", r, {7'b0, in_ready2}, {7'b0, r == 0 || r == 11});
            if (go_pat2[r]) chk("fast_data", r, data_out2, dat2[r / 2 - 1]);
            if (r == 10) chk("fast_result", r, result_out2, 8'h5C);
            @(posedge clk);
            #1;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
